// File: rtl/score_keeper_pkg.sv
// Shared encodings, widths and the score clamp helper for score_keeper.
package score_keeper_pkg;

    localparam int unsigned SCORE_W = 8;
    localparam int unsigned EV_W    = 2;
    localparam int unsigned COMBO_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam logic [EV_W-1:0] EV_SMALL   = 2'd0;
    localparam logic [EV_W-1:0] EV_BIG     = 2'd1;
    localparam logic [EV_W-1:0] EV_PENALTY = 2'd2;

    // Saturate a signed intermediate into [0, max_val].
    function automatic logic [SCORE_W-1:0] clamp_score(input int val, input int max_val);
        if (val < 0)       return '0;
        if (val > max_val) return SCORE_W'(max_val);
        return SCORE_W'(val);
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-event inputs and score/status outputs between the game logic and score_keeper.
interface score_keeper_if;
    import score_keeper_pkg::*;

    logic               start;
    logic               game_over;
    logic               ev_valid;
    logic [EV_W-1:0]    ev_type;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               score_upd;
    logic [1:0]         state;
    logic               new_high;

    modport master (
        output start, game_over, ev_valid, ev_type,
        input  score, high_score, score_upd, state, new_high
    );

    modport slave (
        input  start, game_over, ev_valid, ev_type,
        output score, high_score, score_upd, state, new_high
    );

endinterface

// File: rtl/score_keeper_combo_timer.sv
// Combo window timer: holds the multiplier shift for the next scoring event.
// Only instantiated when SCORE_COMBO_EN is defined.
module score_keeper_combo_timer
    import score_keeper_pkg::*;
#(
    parameter int unsigned WINDOW = 1000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               hit_i,
    input  logic               miss_i,
    input  logic               clear_i,
    output logic [COMBO_W-1:0] combo_o
);

    localparam int unsigned TMR_W = $clog2(WINDOW + 1);
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [COMBO_W-1:0] combo_q, combo_d;

    // combo_q is the shift applied to the next hit; it drops to 0 as the window closes.
    always_comb begin
        timer_d = timer_q;
        combo_d = combo_q;
        if (clear_i || miss_i) begin
            timer_d = '0;
            combo_d = '0;
        end else if (hit_i) begin
            timer_d = TMR_W'(WINDOW);
            combo_d = (combo_q == COMBO_MAX) ? combo_q : combo_q + COMBO_W'(1);
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
            if (timer_q == TMR_W'(1)) combo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
            combo_q <= '0;
        end else begin
            timer_q <= timer_d;
            combo_q <= combo_d;
        end
    end

    assign combo_o = combo_q;

endmodule

// File: rtl/score_keeper.sv
// Clamped running score, session high score and IDLE/PLAY/OVER game FSM.
// Optional combo multiplier enabled by defining SCORE_COMBO_EN.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned MAX_SCORE   = 255,
    parameter int unsigned SMALL_PTS   = 1,
    parameter int unsigned BIG_PTS     = 5,
    parameter int unsigned PENALTY_PTS = 3
`ifdef SCORE_COMBO_EN
    ,
    parameter int unsigned COMBO_WINDOW = 1000
`endif
) (
    input  logic           clk,
    input  logic           resetn,
    score_keeper_if.slave  bus
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               upd_q, upd_d;
    logic               new_high_q, new_high_d;

    logic               ev_accept;
    logic [COMBO_W-1:0] combo;

    // start and game_over both take priority over a same-cycle event.
    assign ev_accept = (state_q == ST_PLAY) && !bus.start && !bus.game_over && bus.ev_valid;

`ifdef SCORE_COMBO_EN
    logic combo_hit, combo_miss, combo_clear;

    assign combo_hit   = ev_accept && ((bus.ev_type == EV_SMALL) || (bus.ev_type == EV_BIG));
    assign combo_miss  = ev_accept && (bus.ev_type == EV_PENALTY);
    assign combo_clear = bus.start || bus.game_over;

    score_keeper_combo_timer #(
        .WINDOW (COMBO_WINDOW)
    ) u_combo_timer (
        .clk     (clk),
        .resetn  (resetn),
        .hit_i   (combo_hit),
        .miss_i  (combo_miss),
        .clear_i (combo_clear),
        .combo_o (combo)
    );
`else
    assign combo = '0;
`endif

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d    = ST_PLAY;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
            end
            ST_PLAY: begin
                if (bus.start) begin
                    score_d    = '0;
                    new_high_d = 1'b0;
                end else if (bus.game_over) begin
                    state_d = ST_OVER;
                end else if (ev_accept) begin
                    case (bus.ev_type)
                        EV_SMALL:   score_d = clamp_score(int'(score_q) + (int'(SMALL_PTS) << combo),
                                                          int'(MAX_SCORE));
                        EV_BIG:     score_d = clamp_score(int'(score_q) + (int'(BIG_PTS) << combo),
                                                          int'(MAX_SCORE));
                        EV_PENALTY: score_d = clamp_score(int'(score_q) - int'(PENALTY_PTS),
                                                          int'(MAX_SCORE));
                        default:    score_d = score_q;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // High score follows the new score in the same edge.
        if (score_d > high_q) begin
            high_d     = score_d;
            new_high_d = 1'b1;
        end

        upd_d = (score_d != score_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            upd_q      <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            upd_q      <= upd_d;
            new_high_q <= new_high_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.score_upd  = upd_q;
    assign bus.state      = state_q;
    assign bus.new_high   = new_high_q;

endmodule
